rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
- Parametrised round-robin arbiter for N requesters, e.g. input ports competing for one router output port.
- A grant is held for as long as the owner keeps its request high, so a packet passes through without interruption. On release, the next requester in rotation receives the grant with no idle bubble.
- An optional hold limit forces rotation when other requesters are waiting.
- Successor to the fixed-priority 10-way arbiter: fairness, configurable width, grant index output.

Parameters:
- N, 10, number of requesters (2..32).
- MAX_HOLD, 0, maximum consecutive grant cycles for one owner while others wait; 0 = unlimited.
- IW, $clog2(N), width of the grant index (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  N  request vector; bit i = requester i.
- gnt  out  N  registered one-hot grant; all zeros when idle.
- gnt_valid  out  1  registered; equals |gnt.
- gnt_idx  out  IW  registered index of the granted requester; 0 when idle.

Interface decision:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.

Behaviour:
- Reset (rst high at a posedge):
  - gnt=0, gnt_valid=0, gnt_idx=0, state=IDLE.
  - Priority pointer ptr=0, so requester 0 has highest priority first.
  - hold_cnt=0.
  - rst overrides all other activity, including mid-grant.
- States: IDLE, GRANT. gnt, gnt_valid and gnt_idx are registered and change only on posedge clk.
- Latency: a request sampled at edge t gives its grant visible after edge t (one cycle). The old design took two cycles.
- Pick function: search req starting at index ptr, wrapping modulo N. The first set bit wins.
- IDLE:
  - If req != 0: grant the pick, go to GRANT, hold_cnt=1.
  - Else stay in IDLE with outputs 0.
- GRANT, owner o:
  - req[o]=1 and no forced rotation: keep the grant. hold_cnt increments and saturates at MAX_HOLD.
  - req[o]=0 and other requests pending: hand over directly to the pick with ptr=(o+1) mod N. The new grant appears at the next edge with no zero cycle. hold_cnt=1.
  - req[o]=0 and no other requests: go to IDLE; gnt=0 at the next edge.
  - Forced rotation applies when MAX_HOLD>0, hold_cnt==MAX_HOLD, req[o]=1 and another req bit is set. Grant moves to the pick from (o+1), excluding o. If no one else requests, o keeps the grant and hold_cnt stays at MAX_HOLD.
- Pointer update: on every new grant to index g, ptr becomes (g+1) mod N.
  - Wrap-around: a grant to N-1 sets ptr=0.
  - ptr is unchanged while a grant is held.
- Simultaneous release and new requests: a new request arriving in the same cycle the owner drops is eligible for the handover pick.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_idx always matches gnt.
  - A requester whose req is low is never granted.
- Non-power-of-two N: indices ≥ N never appear on gnt_idx.

Decomposition:
- Shared package (noc_arb_pkg):
  - State encoding constants ARB_IDLE / ARB_GRANT.
  - A clog2 function.
  - The one-hot-to-index conversion function.
- One combinational sub-module, rr_pick (params N, IW):
  - Inputs: req, ptr, mask (excludes the current owner).
  - Outputs: pick_valid, pick_idx.
  - Implementation is a rotate, priority-encode, un-rotate, or the equivalent double-width trick.
- rr_arbiter holds the state register, ptr, hold_cnt and the output registers.

Test Plan (N=10 unless stated):
- Reset/idle: rst=1 for 2 cycles, then req=0 -> gnt=0, gnt_valid=0, gnt_idx=0 every cycle.
- Latency and hold: req=10'h001 from cycle 5 to 14 -> gnt=10'h001 from cycle 6 to 15, then 0 at cycle 16.
- Round-robin fairness: req=10'h3FF constant, each owner drops req for one cycle after a 3-cycle hold -> grant order 0,1,2,…,9,0 with no idle cycle between owners.
- Direct handover and wrap: owner 9 drops while req[2] and req[5] are high -> next grant is 2 (ptr wrapped to 0), gnt_idx=2.
- Forced rotation: MAX_HOLD=4, req[3]=1 constant plus req[7]=1 from cycle 2 -> grant 3 for exactly 4 cycles, then 7. With req[7]=0 instead, grant 3 is held indefinitely.
- Reset mid-grant: rst=1 while gnt=10'h020 -> gnt=0 next edge. After rst is released with req=10'h021, the grant goes to 0 (ptr reset).

Source files
------------

// File: rtl/noc_arb_pkg.sv
// Shared definitions for the NoC output-port arbiters:
// state encoding and small index helpers.
package noc_arb_pkg;

    localparam logic ARB_IDLE  = 1'b0;
    localparam logic ARB_GRANT = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Valid only for a one-hot or zero input: ORing the set-bit
    // indices gives the index of the single set bit.
    function automatic logic [4:0] oh2idx(input logic [31:0] oh);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) r = r | 5'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first eligible request at or after ptr,
// wrapping modulo N. Combinational only.
module rr_pick
    import noc_arb_pkg::*;
#(
    parameter int N  = 10,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic          pick_valid,
    output logic [IW-1:0] pick_idx
);

    logic [N-1:0]   elig;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    assign elig = req & ~mask;
    assign dbl  = {elig, elig};
    assign rot  = N'(dbl >> ptr);

    // Priority-encode the rotated vector, then rotate the offset back
    always_comb begin
        pick_valid = 1'b0;
        off        = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick_valid = 1'b1;
                off        = IW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
        pick_idx = sum[IW-1:0];
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant hold, zero-bubble handover
// and optional forced rotation after MAX_HOLD cycles.
module rr_arbiter
    import noc_arb_pkg::*;
#(
    parameter int N        = 10,
    parameter int MAX_HOLD = 0,
    parameter int IW       = clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    localparam int HW = (MAX_HOLD > 0) ? clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

    logic          state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          vld_q, vld_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          own_req;
    logic          force_rot;
    logic          take;
    logic          keep;

    // ptr_q already equals (owner+1) mod N while a grant is held,
    // and masking the owner removes it from a forced-rotation pick.
    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .mask       (gnt_q),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx)
    );

    assign own_req   = |(req & gnt_q);
    assign force_rot = (MAX_HOLD > 0) && (hold_q == HMAX)
                       && own_req && pick_valid;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // Next state: new grant, keep current owner, or go idle
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        keep    = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_GRANT;
                    take    = 1'b1;
                end
            end
            ARB_GRANT: begin
                if (own_req && !force_rot) begin
                    keep = 1'b1;
                end else if (pick_valid) begin
                    take = 1'b1;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
        endcase
    end

    // Register next values for grant, pointer and hold counter
    always_comb begin
        gnt_d  = gnt_q;
        vld_d  = vld_q;
        idx_d  = idx_q;
        ptr_d  = ptr_q;
        hold_d = hold_q;
        if (take) begin
            gnt_d  = N'(1) << pick_idx;
            vld_d  = 1'b1;
            idx_d  = IW'(oh2idx(32'(gnt_d)));
            ptr_d  = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
            hold_d = HW'(1);
        end else if (keep) begin
            if ((MAX_HOLD > 0) && (hold_q != HMAX)) begin
                hold_d = hold_q + 1'b1;
            end
        end else if (state_d == ARB_IDLE) begin
            gnt_d  = '0;
            vld_d  = 1'b0;
            idx_d  = '0;
            hold_d = '0;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = vld_q;
    assign gnt_idx   = idx_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: directed scenarios plus
// random traffic against a behavioural round-robin model.
module tb_rr_arbiter;

    localparam int N  = 10;
    localparam int MH = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [3:0]   gnt_idx;

    int checks = 0;
    int errors = 0;

    logic [14:0] expq[$];

    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(logic [N-1:0] r, int start, int excl);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r_rst, input logic [N-1:0] r);
        int  p;
        bit  own;
        bit  others;
        bit  forced;
        if (r_rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            p = pick(r, m_ptr, -1);
            if (p >= 0) begin
                m_owner = p;
                m_ptr   = (p + 1) % N;
                m_hold  = 1;
            end
        end else begin
            own    = r[m_owner];
            others = (r & ~(N'(1) << m_owner)) != 0;
            forced = (MH > 0) && (m_hold == MH) && own && others;
            if (own && !forced) begin
                if (m_hold < MH) m_hold++;
            end else if (others) begin
                p       = pick(r, (m_owner + 1) % N, m_owner);
                m_owner = p;
                m_ptr   = (p + 1) % N;
                m_hold  = 1;
            end else begin
                m_owner = -1;
                m_hold  = 0;
            end
        end
    endtask

    task automatic cyc(input logic r_rst, input logic [N-1:0] r);
        logic [N-1:0] eg;
        logic [3:0]   ei;
        @(negedge clk);
        rst = r_rst;
        req = r;
        model_step(r_rst, r);
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        ei = (m_owner >= 0) ? 4'(m_owner) : 4'd0;
        expq.push_back({eg, ei, m_owner >= 0});
    endtask

    task automatic dchk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: compare registered outputs after each active edge
    always @(posedge clk) begin
        logic [14:0] e;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            if ({gnt, gnt_idx, gnt_valid} !== e) begin
                errors++;
                $display("FAIL model t=%0t: gnt=%h idx=%0d v=%b want gnt=%h idx=%0d v=%b",
                         $time, gnt, gnt_idx, gnt_valid,
                         e[14:5], e[4:1], e[0]);
            end
            checks++;
            if (!$onehot0(gnt)) begin
                errors++;
                $display("FAIL onehot: gnt=%h, want one-hot or zero", gnt);
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        rst = 1'b1;
        req = '0;

        cyc(1, '0);
        cyc(1, '0);
        repeat (3) cyc(0, '0);
        dchk("idle_gnt", int'(gnt), 0);

        repeat (10) cyc(0, 10'h001);
        repeat (3) cyc(0, '0);

        cyc(1, '0);
        for (int i = 0; i <= N; i++) begin
            cyc(0, 10'h3FF);
            cyc(0, 10'h3FF);
            dchk("rr_order", int'(gnt_idx), i % N);
            cyc(0, 10'h3FF);
            cyc(0, 10'h3FF & ~(N'(1) << m_owner));
        end

        cyc(1, '0);
        cyc(0, 10'h200);
        cyc(0, 10'h200);
        cyc(0, 10'h024);
        cyc(0, 10'h024);
        dchk("wrap_idx", int'(gnt_idx), 2);

        cyc(1, '0);
        cyc(0, 10'h008);
        cyc(0, 10'h008);
        cyc(0, 10'h088);
        cyc(0, 10'h088);
        cyc(0, 10'h088);
        dchk("hold4_idx", int'(gnt_idx), 3);
        cyc(0, 10'h088);
        dchk("forced_idx", int'(gnt_idx), 7);

        cyc(1, '0);
        repeat (12) cyc(0, 10'h008);
        dchk("unlim_idx", int'(gnt_idx), 3);

        cyc(1, '0);
        cyc(0, 10'h020);
        cyc(0, 10'h020);
        dchk("pre_rst_gnt", int'(gnt), 'h020);
        cyc(1, 10'h020);
        cyc(0, 10'h021);
        dchk("mid_rst_gnt", int'(gnt), 0);
        cyc(0, 10'h021);
        dchk("post_rst_idx", int'(gnt_idx), 0);

        r = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                r = N'($urandom) & N'($urandom);
            end
            cyc($urandom_range(0, 60) == 0, r);
        end

        repeat (3) @(negedge clk);
        dchk("queue_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
